// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch path
package cpu_pkg;

  // Default widths of the fetch datapath
  localparam int DEF_PC_W    = 6;
  localparam int DEF_INSTR_W = 20;
  localparam int DEF_CNT_W   = 16;

  // M3 next-PC select codes driven by the control FSM
  localparam logic [1:0] PC_SEL_HOLD = 2'b00;
  localparam logic [1:0] PC_SEL_INC  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP  = 2'b10;
  localparam logic [1:0] PC_SEL_HALT = 2'b11;

  // Opcode field position inside the instruction word (decoded by the control FSM)
  localparam int OPCODE_MSB = 19;
  localparam int OPCODE_LSB = 16;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    REQ   = 2'b00,
    ISSUE = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC selection from the M3 code
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [PC_W-1:0] gamma,
  output logic [PC_W-1:0] pc_next
);

  // Hold and halt keep the PC; increment wraps naturally at the PC width
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_SEL_INC:  pc_next = pc + PC_W'(1);
      PC_SEL_JMP:  pc_next = gamma;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction register and fetch handshake
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_req,
  input  logic [1:0]         pc_sel,
  input  logic [PC_W-1:0]    gamma,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic               imem_req_q, imem_req_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [PC_W-1:0]    pc_next;

  pc_next_mux #(
    .PC_W (PC_W)
  ) u_pc_next_mux (
    .pc      (pc_q),
    .pc_sel  (pc_sel),
    .gamma   (gamma),
    .pc_next (pc_next)
  );

  // Next-state and next-output logic; only the input relevant to the current state acts
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fetch_cnt_d   = fetch_cnt_q;

    case (state_q)
      REQ: begin
        imem_req_d = 1'b1;
        // An ack only completes a fetch once the request is actually on the bus
        if (imem_req_q && imem_ack) begin
          instruction_d = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          if (fetch_cnt_q != {CNT_W{1'b1}}) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (next_req) begin
          instr_valid_d = 1'b0;
          if (pc_sel == PC_SEL_HALT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d       = pc_next;
            imem_req_d = 1'b1;
            state_d    = REQ;
          end
        end
      end
      HALT: begin
        imem_req_d = 1'b0;
      end
      default: begin
        state_d = REQ;
      end
    endcase

    // The address register tracks the PC so it is stable for the whole REQ phase
    imem_addr_d = pc_d;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= REQ;
      pc_q          <= '0;
      imem_addr_q   <= '0;
      imem_req_q    <= 1'b0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_addr_q   <= imem_addr_d;
      imem_req_q    <= imem_req_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_req = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [5:0]  gamma = 6'd0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [19:0] imem_rdata = 20'h0;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        halted;
  logic [15:0] fetch_cnt;

  typedef struct packed {
    logic [19:0] instr;
    logic [5:0]  pc;
    logic [15:0] cnt;
  } fetch_exp_t;

  fetch_exp_t  exp_fetch_q[$];
  logic [5:0]  exp_addr_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          done = 1'b0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_req    (next_req),
    .pc_sel      (pc_sel),
    .gamma       (gamma),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every new request address and every newly issued instruction
  initial begin
    logic prev_req = 1'b0;
    logic prev_valid = 1'b0;
    fetch_exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) check("unexpected_req", 32'(imem_addr), 32'hDEAD);
        else check("req_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (instr_valid && !prev_valid) begin
        if (exp_fetch_q.size() == 0) check("unexpected_issue", 32'(instruction), 32'hDEAD);
        else begin
          e = exp_fetch_q.pop_front();
          check("issue_instr", 32'(instruction), 32'(e.instr));
          check("issue_pc", 32'(pc), 32'(e.pc));
          check("issue_cnt", 32'(fetch_cnt), 32'(e.cnt));
          check("issue_req_low", 32'(imem_req), 32'h0);
        end
      end
      prev_req = imem_req;
      prev_valid = instr_valid;
    end
  end

  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) check("req_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_fetch(input logic [19:0] data, input int delay);
    wait_req();
    repeat (delay) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 20'h0;
  endtask

  task automatic do_next(input logic [1:0] sel, input logic [5:0] g);
    int n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check("valid_timeout", 32'h0, 32'h1);
    next_req = 1'b1;
    pc_sel = sel;
    gamma = g;
    @(negedge clk);
    next_req = 1'b0;
    pc_sel = 2'b00;
    gamma = 6'd0;
  endtask

  function automatic fetch_exp_t fe(input logic [19:0] i, input logic [5:0] p, input logic [15:0] c);
    fetch_exp_t r;
    r.instr = i;
    r.pc = p;
    r.cnt = c;
    return r;
  endfunction

  initial begin
    bit saw_req;
    // Reset values
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_cnt", 32'(fetch_cnt), 32'h0);
    exp_addr_q.push_back(6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First fetch, acked on the second REQ cycle
    exp_fetch_q.push_back(fe(20'h53100, 6'd0, 16'd1));
    do_fetch(20'h53100, 1);

    // Sequential fetches 1,2,3 with immediate ack
    for (int i = 1; i <= 3; i++) begin
      exp_addr_q.push_back(6'(i));
      exp_fetch_q.push_back(fe(20'h1A000 + 20'(i), 6'(i), 16'(1 + i)));
      do_next(2'b01, 6'd0);
      do_fetch(20'h1A000 + 20'(i), 0);
    end

    // Jump to 63 then increment wraps to 0
    exp_addr_q.push_back(6'd63);
    exp_fetch_q.push_back(fe(20'h2B03F, 6'd63, 16'd5));
    do_next(2'b10, 6'd63);
    do_fetch(20'h2B03F, 0);
    exp_addr_q.push_back(6'd0);
    exp_fetch_q.push_back(fe(20'h2B000, 6'd0, 16'd6));
    do_next(2'b01, 6'd0);
    do_fetch(20'h2B000, 0);

    // Jump to 5, jump to 42, refetch 42 with new data
    exp_addr_q.push_back(6'd5);
    exp_fetch_q.push_back(fe(20'h3C005, 6'd5, 16'd7));
    do_next(2'b10, 6'd5);
    do_fetch(20'h3C005, 2);
    exp_addr_q.push_back(6'd42);
    exp_fetch_q.push_back(fe(20'h3C02A, 6'd42, 16'd8));
    do_next(2'b10, 6'd42);
    do_fetch(20'h3C02A, 0);
    exp_addr_q.push_back(6'd42);
    exp_fetch_q.push_back(fe(20'h4D02A, 6'd42, 16'd9));
    do_next(2'b00, 6'd17);
    do_fetch(20'h4D02A, 0);

    // Ack pulsed in ISSUE is ignored
    imem_ack = 1'b1;
    imem_rdata = 20'hFFFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 20'h0;
    @(negedge clk);
    check("ign_ack_instr", 32'(instruction), 32'h4D02A);
    check("ign_ack_cnt", 32'(fetch_cnt), 32'd9);
    check("ign_ack_valid", 32'(instr_valid), 32'h1);

    // next_req pulsed in REQ is ignored
    exp_addr_q.push_back(6'd43);
    do_next(2'b01, 6'd0);
    wait_req();
    next_req = 1'b1;
    pc_sel = 2'b10;
    gamma = 6'd7;
    @(negedge clk);
    next_req = 1'b0;
    pc_sel = 2'b00;
    gamma = 6'd0;
    check("ign_next_pc", 32'(pc), 32'd43);
    check("ign_next_addr", 32'(imem_addr), 32'd43);
    exp_fetch_q.push_back(fe(20'h5E02B, 6'd43, 16'd10));
    do_fetch(20'h5E02B, 0);

    // Halt is terminal until reset
    do_next(2'b11, 6'd0);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_valid", 32'(instr_valid), 32'h0);
    check("halt_pc", 32'(pc), 32'd43);
    saw_req = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) saw_req = 1'b1;
    end
    check("halt_req_low", 32'(saw_req), 32'h0);
    next_req = 1'b1;
    pc_sel = 2'b01;
    imem_ack = 1'b1;
    imem_rdata = 20'hABCDE;
    @(negedge clk);
    next_req = 1'b0;
    pc_sel = 2'b00;
    imem_ack = 1'b0;
    imem_rdata = 20'h0;
    repeat (2) @(negedge clk);
    check("halt_stuck_pc", 32'(pc), 32'd43);
    check("halt_stuck_cnt", 32'(fetch_cnt), 32'd10);
    check("halt_stuck_instr", 32'(instruction), 32'h5E02B);
    check("halt_stuck_halted", 32'(halted), 32'h1);

    // Leave halt through reset, then fetch and jump to 9
    rst_n = 1'b0;
    exp_addr_q.push_back(6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fetch_q.push_back(fe(20'h6F000, 6'd0, 16'd1));
    do_fetch(20'h6F000, 0);
    exp_addr_q.push_back(6'd9);
    do_next(2'b10, 6'd9);
    wait_req();
    check("midrst_pre_pc", 32'(pc), 32'd9);

    // Reset mid-fetch takes effect before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'h0);
    check("midrst_pc", 32'(pc), 32'h0);
    exp_addr_q.push_back(6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req();
    repeat (3) @(negedge clk);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'h0);
    check("fetch_q_drained", 32'(exp_fetch_q.size()), 32'h0);
    done = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the instruction word and owns the program counter for the control FSM.
- It is the other end of the fetch2/jmp/jmpz path: the control FSM selects the next PC with the M3 code and supplies the 6-bit jump target gamma.
- This block fetches the word from instruction memory through a req/ack handshake, holds it stable in the instruction register, and advances the PC only when the control FSM asks for the next instruction.

Parameters:
- PC_W, 6: program counter width; matches the gamma width.
- INSTR_W, 20: instruction word width; opcode is bits [19:16].
- CNT_W, 16: width of the saturating fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- next_req  in  1  one-cycle strobe from the control FSM: current instruction consumed, select the next PC.
- pc_sel  in  2  M3 code, sampled with next_req: 00 refetch same PC, 01 PC+1, 10 jump to gamma, 11 halt.
- gamma  in  PC_W  jump target, sampled with next_req when pc_sel=10.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  PC_W  read address; equals pc while imem_req=1.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  INSTR_W  memory read data.
- instruction  out  INSTR_W  instruction register, drives the control FSM.
- instr_valid  out  1  instruction register holds a fresh, unconsumed word.
- pc  out  PC_W  current program counter.
- halted  out  1  fetch stopped by pc_sel=11.
- fetch_cnt  out  CNT_W  completed fetches, saturating.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- All outputs are registered.
- Reset values: pc=0, instruction=0, instr_valid=0, imem_req=0, imem_addr=0, halted=0, fetch_cnt=0, state=REQ.
- Reset takes effect immediately and asynchronously, including mid-handshake. imem_req drops without waiting for ack.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. Wait for imem_ack.
  - ISSUE: instr_valid=1, instruction held stable.
  - HALT: terminal until reset.
- REQ -> ISSUE:
  - Condition: clock edge with imem_ack=1.
  - Actions at that edge: instruction<=imem_rdata, imem_req<=0, instr_valid<=1, fetch_cnt increments (saturating at all-ones).
- Minimum fetch latency: ack present in the first REQ cycle gives instr_valid one cycle later.
- imem_ack outside REQ is ignored; instruction is unchanged.
- imem_rdata is sampled only on an accepted ack.
- ISSUE -> REQ on next_req=1 with pc_sel != 11. At that edge instr_valid<=0, and:
  - pc_sel 00: pc unchanged.
  - pc_sel 01: pc<=pc+1, modulo 2^PC_W (pc=63 wraps to 0).
  - pc_sel 10: pc<=gamma.
- ISSUE -> HALT on next_req=1 with pc_sel=11: instr_valid<=0, halted<=1, imem_req stays 0, pc unchanged.
- next_req outside ISSUE is ignored. pc, state and counter are unaffected.
- next_req and imem_ack in the same cycle: only the input relevant to the current state acts.
- In ISSUE, instruction and pc stay constant until next_req.
- imem_addr updates together with pc. It is valid from the first REQ cycle onward and held constant through the whole REQ phase.
- No opcode decoding in this block; opcode interpretation stays in the control FSM.

Decomposition:
- Shared package (cpu_pkg):
  - PC_SEL_HOLD=2'b00, PC_SEL_INC=2'b01, PC_SEL_JMP=2'b10, PC_SEL_HALT=2'b11.
  - OPCODE_MSB=19, OPCODE_LSB=16.
  - INSTR_W and PC_W defaults.
  - Fetch state enum: REQ, ISSUE, HALT.
- One natural sub-module: pc_next_mux, combinational next-PC selection from pc, pc_sel and gamma.
- The FSM, instruction register and counter stay in instr_fetch_unit.

Test Plan:
- Reset then ack on the second REQ cycle with rdata=20'h5_3100 -> instr_valid rises the following cycle, instruction=20'h53100, pc=0, fetch_cnt=1, imem_req low.
- Sequential fetch: three next_req with pc_sel=01, each acked immediately -> imem_addr sequence 1,2,3 and fetch_cnt=4. With pc preset to 63 via jump, pc_sel=01 -> imem_addr=0.
- Jump: pc=5, next_req with pc_sel=10 and gamma=6'd42 -> next imem_addr=42. Refetch with pc_sel=00 -> imem_addr stays 42 and instruction is reloaded.
- Halt: next_req with pc_sel=11 -> halted=1, instr_valid=0, imem_req stays 0 for 20 cycles. Later next_req and imem_ack pulses change nothing.
- Ignored inputs: imem_ack pulsed in ISSUE with rdata=20'hFFFFF -> instruction unchanged. next_req pulsed in REQ -> pc unchanged.
- Reset mid-fetch: rst_n low while imem_req=1 -> imem_req, instr_valid and pc drop to 0 before the next clk edge. After release the first imem_addr is 0.
